// File: rtl/display_scan_ctrl.sv
// Scans four parity-checked digit slots through one shared Display decoder; segments captured at end of dead-time.
// Latency: first anode BLANK+1 edges after enable; no backpressure, writes accepted every cycle.
module display_scan_ctrl #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 8
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Habilita,
  input  logic       Escrita,
  input  logic [1:0] Endereco,
  input  logic [4:0] Dado,
  input  logic       ParidadeIn,
  output logic [4:0] Valores,
  output logic       Paridade,
  input  logic [6:0] SegmentosIn,
  input  logic       ValidadeIn,
  output logic [3:0] Anodos,
  output logic [6:0] SegmentosOut,
  output logic [1:0] Indice,
  output logic [3:0] Erro,
  output logic [7:0] ErroCont
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_indice, w_indice_nxt;
  logic [3:0]  r_anodos, w_anodos_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic [3:0]  r_erro, w_erro_nxt;
  logic [7:0]  r_erro_cont, w_erro_cont_nxt;
  logic [4:0]  r_valor [4];
  logic [3:0]  r_paridade;
  logic        w_capture;
  logic        w_fail;

  assign Valores      = r_valor[r_indice];
  assign Paridade     = r_paridade[r_indice];
  assign Anodos       = r_anodos;
  assign SegmentosOut = r_seg;
  assign Indice       = r_indice;
  assign Erro         = r_erro;
  assign ErroCont     = r_erro_cont;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_indice    <= '0;
      r_anodos    <= 4'b1111;
      r_seg       <= '0;
      r_erro      <= '0;
      r_erro_cont <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_indice    <= w_indice_nxt;
      r_anodos    <= w_anodos_nxt;
      r_seg       <= w_seg_nxt;
      r_erro      <= w_erro_nxt;
      r_erro_cont <= w_erro_cont_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) r_valor[i] <= '0;
      r_paridade <= '0;
    end else if (Escrita) begin
      r_valor[Endereco]    <= Dado;
      r_paridade[Endereco] <= ParidadeIn;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_indice_nxt = r_indice;
    w_anodos_nxt = r_anodos;
    w_seg_nxt    = r_seg;
    w_capture    = 1'b0;
    if (!Habilita) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_anodos_nxt = 4'b1111;
      w_seg_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_BLANK;
          w_cnt_nxt    = '0;
          w_anodos_nxt = 4'b1111;
          w_seg_nxt    = '0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            // Decoder output has had the whole dead-time to settle on this slot.
            w_capture    = 1'b1;
            w_seg_nxt    = ValidadeIn ? SegmentosIn : 7'd0;
            w_anodos_nxt = ~(4'b0001 << r_indice);
            w_state_nxt  = S_SHOW;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_anodos_nxt = 4'b1111;
            w_seg_nxt    = '0;
            w_indice_nxt = r_indice + 2'd1;
            w_state_nxt  = S_BLANK;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_anodos_nxt = 4'b1111;
          w_seg_nxt    = '0;
        end
      endcase
    end
  end

  assign w_fail = w_capture & ~ValidadeIn;

  // A failed capture on the same edge as a write to that slot keeps the flag set.
  always_comb begin
    w_erro_nxt      = r_erro;
    w_erro_cont_nxt = r_erro_cont;
    if (Escrita) w_erro_nxt[Endereco] = 1'b0;
    if (w_fail) begin
      w_erro_nxt[r_indice] = 1'b1;
      if (r_erro_cont != 8'hFF) w_erro_cont_nxt = r_erro_cont + 8'd1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised scoreboard bench for display_scan_ctrl with a phase-arithmetic reference model.
module tb_display_scan_ctrl;
  localparam int DW  = 4;
  localparam int BL  = 2;
  localparam int PER = DW + BL;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Habilita = 1'b0;
  logic       Escrita = 1'b0;
  logic [1:0] Endereco = '0;
  logic [4:0] Dado = '0;
  logic       ParidadeIn = 1'b0;
  logic [4:0] Valores;
  logic       Paridade;
  logic [6:0] SegmentosIn;
  logic       ValidadeIn;
  logic [3:0] Anodos;
  logic [6:0] SegmentosOut;
  logic [1:0] Indice;
  logic [3:0] Erro;
  logic [7:0] ErroCont;

  display_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Habilita(Habilita), .Escrita(Escrita),
    .Endereco(Endereco), .Dado(Dado), .ParidadeIn(ParidadeIn),
    .Valores(Valores), .Paridade(Paridade), .SegmentosIn(SegmentosIn),
    .ValidadeIn(ValidadeIn), .Anodos(Anodos), .SegmentosOut(SegmentosOut),
    .Indice(Indice), .Erro(Erro), .ErroCont(ErroCont)
  );

  always #5 Clock = ~Clock;

  function automatic logic [6:0] hex7(input logic [4:0] v);
    logic [6:0] s;
    case (v[3:0])
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s ^ {7{v[4]}};
  endfunction

  // Stand-in for the shared Display: even parity over {value, parity} is valid.
  always_comb begin
    SegmentosIn = hex7(Valores);
    ValidadeIn  = ~^{Valores, Paridade};
  end

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
    logic [3:0] erro;
    logic [7:0] cnt;
  } obs_t;

  obs_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  logic [4:0] m_val [4];
  logic [3:0] m_par;
  bit         m_active;
  int         m_phase;
  int         m_start;
  logic [1:0] m_idx;
  logic [6:0] m_seg;
  logic [3:0] m_erro;
  int         m_errs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge Clock) begin : mon
    obs_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {Anodos, SegmentosOut, Indice, Erro, ErroCont};
      check("cycle {an,seg,idx,erro,cnt}", 32'(g), 32'(e));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = '0;
    m_par = '0; m_active = 0; m_phase = 0; m_start = 0;
    m_idx = '0; m_seg = '0; m_erro = '0; m_errs = 0;
  endtask

  // Digit k of a run is captured at phase BL + k*PER and lit for DW edges after that.
  task automatic model_edge(input bit hab, input bit wr, input logic [1:0] a,
                            input logic [4:0] d, input bit p);
    bit fail = 0;
    bit lit = 0;
    logic [3:0] an;
    if (!hab) m_active = 0;
    else if (!m_active) begin m_active = 1; m_phase = 0; m_start = int'(m_idx); end
    else m_phase++;
    if (m_active) begin
      m_idx = 2'((m_start + m_phase / PER) % 4);
      if (m_phase >= BL && (m_phase - BL) % PER == 0) begin
        if (^{m_val[m_idx], m_par[m_idx]}) begin fail = 1; m_seg = '0; end
        else m_seg = hex7(m_val[m_idx]);
      end
      lit = (m_phase >= BL) && ((m_phase - BL) % PER < DW);
    end
    if (wr) begin m_val[a] = d; m_par[a] = p; m_erro[a] = 1'b0; end
    if (fail) begin m_erro[m_idx] = 1'b1; m_errs++; end
    an = 4'b0001 << m_idx;
    q.push_back({lit ? ~an : 4'hF, lit ? m_seg : 7'h00, m_idx, m_erro,
                 8'(m_errs > 255 ? 255 : m_errs)});
  endtask

  task automatic step(input bit hab, input bit wr, input logic [1:0] a,
                      input logic [4:0] d, input bit p);
    Habilita = hab; Escrita = wr; Endereco = a; Dado = d; ParidadeIn = p;
    @(posedge Clock);
    model_edge(hab, wr, a, d, p);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'd0, 5'd0, 0);
  endtask

  function automatic bit next_captures(input logic [1:0] slot);
    int np = m_phase + 1;
    return m_active && np >= BL && (np - BL) % PER == 0 && 2'((m_start + np / PER) % 4) == slot;
  endfunction

  function automatic bit lit_on(input logic [1:0] slot, input int offs);
    return m_active && m_phase >= BL && (m_phase - BL) % PER == offs && m_idx == slot;
  endfunction

  initial begin
    int guard;
    model_reset();
    #1 Reset_n = 1'b0;
    #1;
    check("reset_anodos", 32'(Anodos), 32'hF);
    check("reset_seg", 32'(SegmentosOut), 32'h0);
    check("reset_indice", 32'(Indice), 32'h0);
    check("reset_erro", 32'(Erro), 32'h0);
    check("reset_errocont", 32'(ErroCont), 32'h0);
    #1 Reset_n = 1'b1;

    step(0, 1, 2'd0, 5'd0, 0);
    step(0, 1, 2'd1, 5'd1, 1);
    step(0, 1, 2'd2, 5'd2, 1);
    step(0, 1, 2'd3, 5'd4, 1);
    run(2);
    check("first_lit_not_before_blank+1", 32'(Anodos), 32'hF);
    run(1);
    check("first_lit_at_blank+1", 32'(Anodos), 32'hE);
    run(8 * PER);

    step(1, 1, 2'd1, 5'd1, 0);
    run(2 * 4 * PER);
    step(1, 1, 2'd1, 5'd1, 1);
    run(4 * PER);

    step(1, 1, 2'd2, 5'd7, 0);
    guard = 0;
    while (!next_captures(2'd2) && guard < 100) begin run(1); guard++; end
    check("wait_capture_slot2", 32'(next_captures(2'd2)), 32'h1);
    step(1, 1, 2'd2, 5'd3, 0);
    run(2 * 4 * PER);

    guard = 0;
    while (!lit_on(2'd2, 1) && guard < 100) begin run(1); guard++; end
    check("wait_show_slot2", 32'(lit_on(2'd2, 1)), 32'h1);
    for (int i = 0; i < 5; i++) step(0, 0, 2'd0, 5'd0, 0);
    check("disable_anodos", 32'(Anodos), 32'hF);
    check("disable_indice_held", 32'(Indice), 32'h2);
    run(BL);
    check("resume_blank", 32'(Anodos), 32'hF);
    run(1);
    check("resume_slot2", 32'(Anodos), 32'hB);
    run(4 * PER);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) step(1, 1, 2'(i), 5'd1, 0);
    run(70 * 4 * PER);
    check("errocont_saturated", 32'(ErroCont), 32'd255);
    check("erro_all_set", 32'(Erro), 32'hF);

    for (int i = 0; i < 4; i++) step(1, 1, 2'(i), 5'(i + 8), 1);
    guard = 0;
    while (!lit_on(2'd3, 2) && guard < 100) begin run(1); guard++; end
    check("wait_show_slot3", 32'(lit_on(2'd3, 2)), 32'h1);
    @(negedge Clock);
    #1 Reset_n = 1'b0;
    #1;
    check("midshow_reset_anodos", 32'(Anodos), 32'hF);
    check("midshow_reset_seg", 32'(SegmentosOut), 32'h0);
    check("midshow_reset_indice", 32'(Indice), 32'h0);
    check("midshow_reset_erro", 32'(Erro), 32'h0);
    check("midshow_reset_errocont", 32'(ErroCont), 32'h0);
    check("midshow_reset_slot0", 32'({Valores, Paridade}), 32'h0);
    model_reset();
    Habilita = 1'b0;
    #1 Reset_n = 1'b1;
    run(BL + 1 + PER);
    @(negedge Clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scheduler that shares one `Display` parity-checking 7-segment decoder among four digit slots of a multi-digit common-anode panel. It holds four 5-bit values with their parity bits, feeds one at a time to the shared decoder, and registers the returned segments and validity. It drives the digit anodes with a dead-time between digits, blanks and flags any slot whose parity check fails, and keeps a saturating error count.

## Interface
- `DWELL`, 1000: clock cycles each digit is lit; legal range 1..65535.
- `BLANK`, 8: dead-time cycles with all anodes off before each digit; legal range 1..65535.
- `Clock`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Habilita`  in  1  scan enable; low parks the block in IDLE.
- `Escrita`  in  1  slot write strobe, one cycle per write.
- `Endereco`  in  2  slot index for the write.
- `Dado`  in  5  value written to the slot.
- `ParidadeIn`  in  1  parity bit written to the slot.
- `Valores`  out  5  value to the shared `Display`; equals `slot[Indice].valor`, combinational.
- `Paridade`  out  1  parity to the shared `Display`; equals `slot[Indice].paridade`, combinational.
- `SegmentosIn`  in  7  segment pattern from the shared `Display`.
- `ValidadeIn`  in  1  validity flag from the shared `Display`.
- `Anodos`  out  4  digit enables, active-low, one-hot when lit.
- `SegmentosOut`  out  7  registered segments, active-high.
- `Indice`  out  2  slot currently selected.
- `Erro`  out  4  sticky per-slot parity-error flags.
- `ErroCont`  out  8  saturating count of failed captures.

## Operation
- **Storage.** Four slot registers of {valor[4:0], paridade}. Reset value is {0, 0}, which is valid even parity.
- **Writes.** `Escrita` writes `Dado`/`ParidadeIn` into `slot[Endereco]` on the clock edge. Writes are accepted in every state. A write to slot i clears `Erro[i]`.
- **FSM states.** IDLE, BLANK and SHOW. A 16-bit counter `cnt` and a 2-bit `Indice` support the sequencing.
- **IDLE.** `Anodos`=1111, `SegmentosOut`=0, `cnt`=0, `Indice` is held.
  - `Habilita`=1 → BLANK, with `cnt`=0.
- **BLANK.** `Anodos`=1111 and `SegmentosOut`=0. `Valores`/`Paridade` already present the slot at `Indice`.
  - On the edge where `cnt`==BLANK-1, the block captures `SegmentosIn` and `ValidadeIn`.
  - If `ValidadeIn`=1: `SegmentosOut`<=`SegmentosIn`.
  - If `ValidadeIn`=0: `SegmentosOut`<=0, `Erro[Indice]`<=1, and `ErroCont` increments, saturating at 255.
  - On that same edge, `Anodos[Indice]`<=0 (others 1), state → SHOW, `cnt`<=0.
- **SHOW.** Segments and anode are held.
  - On the edge where `cnt`==DWELL-1: `Anodos`<=1111, `SegmentosOut`<=0, `Indice`<=`Indice`+1 (wraps 3→0), state → BLANK, `cnt`<=0.
- **Disable.** `Habilita`=0 sampled in any state → IDLE on that edge, with outputs as listed for IDLE.
- **Write/capture collision.** A write to the slot being captured on the same edge does not affect that capture, because the decoder sees the old value. The new value appears at that slot's next scan. If the capture fails on that same edge, the `Erro` set wins over the write clear.
- **Mid-dwell writes.** A write to the lit slot during SHOW does not change `SegmentosOut` until the next visit.
- **Async reset.** `Reset_n`=0 forces IDLE at once:
  - `Anodos`=1111, `SegmentosOut`=0, `Indice`=0, `cnt`=0.
  - `Erro`=0, `ErroCont`=0, all slots {0, 0}.
  - This applies at any point, including mid-SHOW.

## Timing
- All outputs except `Valores`/`Paridade` are registered. The `Display` path (`Valores`/`Paridade` → `SegmentosIn`/`ValidadeIn`) is combinational and must settle within one clock.
- From `Habilita` sampled high in IDLE to the first anode asserted: BLANK+1 edges.
- Full scan period: 4×(BLANK+DWELL) cycles. Each digit is lit for exactly DWELL cycles.
- From a write to slot i to its visible effect: the next capture of slot i, at most 4×(BLANK+DWELL) cycles later.
- Anodes are never asserted in overlapping cycles. At least BLANK cycles with all anodes off separate any two lit digits.

## Test plan
- **Reset defaults.** Assert `Reset_n`=0 mid-SHOW → `Anodos`=1111, `SegmentosOut`=0, `Indice`=0, `Erro`=0 and `ErroCont`=0 immediately, without waiting for a clock edge.
- **Scan order** (DWELL=4, BLANK=2). Write slots 0..3 with {0,0}, {1,1}, {2,1}, {4,1}, then raise `Habilita` → `Anodos` goes 1110, 1101, 1011, 0111, each lit for 4 cycles and separated by 2 cycles of 1111. The first anode appears 3 edges after enable, and segments match the digits 0, 1, 2, 4.
- **Parity fail.** Write slot 1 with {1,0} → during slot 1's SHOW, `SegmentosOut`=0 and `Erro`=0010. `ErroCont` increments once per scan. Rewriting slot 1 with {1,1} clears `Erro[1]`, and the digit shows on the next visit.
- **Saturation.** Write all slots invalid and run 70 scans → `ErroCont` holds at 255.
- **Collision.** Write slot 2 on the edge where slot 2 is captured → this scan shows the old value and the next scan shows the new value.
- **Disable mid-scan.** Drop `Habilita` during SHOW of slot 2 → the next edge gives 1111 and IDLE with `Indice`=2 held. Re-enabling resumes at slot 2 after BLANK+1 edges.
